// File: rtl/vga_game_pkg.sv
// -----------------------------------------------------------------------------
// vga_game_pkg
// Purpose : shared definitions for the VGA block game datapath: default screen
//           geometry, colour constants, the screen-edge behaviour selector and
//           the move-scheduling FSM state type.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package vga_game_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  localparam logic [7:0] COLOR_FG = 8'hFF;
  localparam logic [7:0] COLOR_BG = 8'h00;

  // Behaviour when a move would push the block past a screen edge
  typedef enum logic {
    EDGE_CLAMP,
    EDGE_WRAP
  } edge_mode_e;

  // Move scheduler: IDLE (nothing queued), ARMED (waiting for frame_tick),
  // COMMIT (single cycle in which queued moves are applied)
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT
  } state_e;

endpackage

// File: rtl/block_axis_step.sv
// -----------------------------------------------------------------------------
// block_axis_step
// Purpose : combinational next-position logic for one axis of the block.
//           Applies +STEP / -STEP and clamps or wraps at the [0, LIM] range.
// Ports   : p       in   COORD_W  current top-left coordinate on this axis
//           inc     in   1        move in the + direction
//           dec     in   1        move in the - direction
//           mode    in   enum     EDGE_CLAMP / EDGE_WRAP
//           p_next  out  COORD_W  coordinate after the move
//           hit     out  1        the move was clamped or wrapped
// -----------------------------------------------------------------------------
module block_axis_step
  import vga_game_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int LIM     = 760,
  parameter int STEP    = 8
) (
  input  logic [COORD_W-1:0] p,
  input  logic               inc,
  input  logic               dec,
  input  edge_mode_e         mode,
  output logic [COORD_W-1:0] p_next,
  output logic               hit
);

  // One extra bit so p+STEP cannot overflow before the limit compare
  localparam int W = COORD_W + 1;
  localparam logic [W-1:0] LIM_W  = W'(LIM);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] w_pExt;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;

  assign w_pExt = {1'b0, p};
  assign w_sum  = w_pExt + STEP_W;
  assign w_diff = w_pExt - STEP_W;

  // inc and dec together cancel: no move and no hit
  always_comb begin
    p_next = p;
    hit    = 1'b0;
    if (inc && !dec) begin
      if (w_sum > LIM_W) begin
        hit    = 1'b1;
        p_next = (mode == EDGE_WRAP) ? '0 : LIM_W[COORD_W-1:0];
      end else begin
        p_next = w_sum[COORD_W-1:0];
      end
    end else if (dec && !inc) begin
      if (w_pExt < STEP_W) begin
        hit    = 1'b1;
        p_next = (mode == EDGE_WRAP) ? LIM_W[COORD_W-1:0] : '0;
      end else begin
        p_next = w_diff[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/block_mover_ctrl.sv
// -----------------------------------------------------------------------------
// block_mover_ctrl
// Purpose : holds the position of one rectangle, queues direction presses and
//           applies them only at frame boundaries (no tearing), then renders
//           the block as a registered pixel colour for vga_ctrl.
// Ports   : clk         in   1        pixel clock
//           rst_n       in   1        asynchronous active-low reset
//           key_up/down/left/right in 1  single-cycle press pulses
//           frame_tick  in   1        pulse at first line of vertical blanking
//           vga_xide    in   COORD_W  current active pixel x
//           vga_yide    in   COORD_W  current active pixel y
//           vga_data    out  8        pixel colour, 1-cycle latency
//           blk_x/blk_y out  COORD_W  block top-left corner
//           edge_hits   out  8        saturating count of clamped/wrapped moves
//           pending     out  1        a move is waiting for frame_tick
// -----------------------------------------------------------------------------
module block_mover_ctrl
  import vga_game_pkg::*;
#(
  parameter int         H_ACTIVE = H_ACTIVE_DEF,
  parameter int         V_ACTIVE = V_ACTIVE_DEF,
  parameter int         COORD_W  = 10,
  parameter int         BLK_W    = 40,
  parameter int         BLK_H    = 40,
  parameter int         STEP     = 8,
  parameter int         WRAP     = 0,
  parameter int         X0       = 380,
  parameter int         Y0       = 280,
  parameter logic [7:0] FG       = COLOR_FG,
  parameter logic [7:0] BG       = COLOR_BG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] vga_xide,
  input  logic [COORD_W-1:0] vga_yide,
  output logic [7:0]         vga_data,
  output logic [COORD_W-1:0] blk_x,
  output logic [COORD_W-1:0] blk_y,
  output logic [7:0]         edge_hits,
  output logic               pending
);

  localparam int LIM_X = H_ACTIVE - BLK_W;
  localparam int LIM_Y = V_ACTIVE - BLK_H;
  localparam edge_mode_e MODE = (WRAP != 0) ? EDGE_WRAP : EDGE_CLAMP;

  if (X0 < 0 || X0 > LIM_X) begin : g_badX0
    $error("block_mover_ctrl: X0 outside 0..H_ACTIVE-BLK_W");
  end
  if (Y0 < 0 || Y0 > LIM_Y) begin : g_badY0
    $error("block_mover_ctrl: Y0 outside 0..V_ACTIVE-BLK_H");
  end

  // Pend flag bit order: {up, down, left, right}
  localparam int P_UP    = 3;
  localparam int P_DOWN  = 2;
  localparam int P_LEFT  = 1;
  localparam int P_RIGHT = 0;

  state_e             r_state;
  logic [3:0]         r_pend;
  logic [COORD_W-1:0] r_blkX;
  logic [COORD_W-1:0] r_blkY;
  logic [7:0]         r_edgeHits;
  logic [7:0]         r_vgaData;

  logic [3:0]         w_keys;
  logic               w_anyKey;
  logic [COORD_W-1:0] w_nextX;
  logic [COORD_W-1:0] w_nextY;
  logic               w_hitX;
  logic               w_hitY;
  logic [8:0]         w_hitSum;
  logic [7:0]         w_hitsSat;

  assign w_keys   = {key_up, key_down, key_left, key_right};
  assign w_anyKey = |w_keys;

  block_axis_step #(
    .COORD_W (COORD_W),
    .LIM     (LIM_X),
    .STEP    (STEP)
  ) u_axisX (
    .p      (r_blkX),
    .inc    (r_pend[P_RIGHT]),
    .dec    (r_pend[P_LEFT]),
    .mode   (MODE),
    .p_next (w_nextX),
    .hit    (w_hitX)
  );

  block_axis_step #(
    .COORD_W (COORD_W),
    .LIM     (LIM_Y),
    .STEP    (STEP)
  ) u_axisY (
    .p      (r_blkY),
    .inc    (r_pend[P_DOWN]),
    .dec    (r_pend[P_UP]),
    .mode   (MODE),
    .p_next (w_nextY),
    .hit    (w_hitY)
  );

  // Up to two hits per commit; one spare bit detects saturation
  assign w_hitSum  = {1'b0, r_edgeHits} + {8'd0, w_hitX} + {8'd0, w_hitY};
  assign w_hitsSat = w_hitSum[8] ? 8'hFF : w_hitSum[7:0];

  // Move scheduler. In COMMIT the old flags are consumed and replaced by any
  // press arriving in that same cycle, so that press lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_blkX     <= COORD_W'(X0);
      r_blkY     <= COORD_W'(Y0);
      r_edgeHits <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pend <= w_keys;
          if (w_anyKey) r_state <= ARMED;
        end
        ARMED: begin
          r_pend <= r_pend | w_keys;
          if (frame_tick) r_state <= COMMIT;
        end
        COMMIT: begin
          r_blkX     <= w_nextX;
          r_blkY     <= w_nextY;
          r_edgeHits <= w_hitsSat;
          r_pend     <= w_keys;
          r_state    <= w_anyKey ? ARMED : IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_pend  <= '0;
        end
      endcase
    end
  end

  // Pixel path; the end bounds are one bit wider so blk+size cannot wrap
  logic [COORD_W:0] w_xEnd;
  logic [COORD_W:0] w_yEnd;
  logic             w_inBlk;

  assign w_xEnd  = {1'b0, r_blkX} + (COORD_W+1)'(BLK_W);
  assign w_yEnd  = {1'b0, r_blkY} + (COORD_W+1)'(BLK_H);
  assign w_inBlk = (vga_xide >= r_blkX) && ({1'b0, vga_xide} < w_xEnd) &&
                   (vga_yide >= r_blkY) && ({1'b0, vga_yide} < w_yEnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vgaData <= BG;
    end else begin
      r_vgaData <= w_inBlk ? FG : BG;
    end
  end

  assign vga_data  = r_vgaData;
  assign blk_x     = r_blkX;
  assign blk_y     = r_blkY;
  assign edge_hits = r_edgeHits;
  assign pending   = (r_state != IDLE);

endmodule

// File: tb/tb_block_mover_ctrl.sv
// -----------------------------------------------------------------------------
// tb_block_mover_ctrl
// Directed-vector bench for block_mover_ctrl. Three instances share all inputs:
// the default configuration, a clamp instance parked at the right edge and a
// wrap instance parked at the left edge.
// -----------------------------------------------------------------------------
module tb_block_mover_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] vga_xide = '0;
  logic [9:0] vga_yide = '0;

  logic [7:0] dData,  cData,  wData;
  logic [9:0] dX, dY, cX, cY, wX, wY;
  logic [7:0] dHits, cHits, wHits;
  logic       dPend, cPend, wPend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_mover_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .frame_tick(frame_tick),
    .vga_xide(vga_xide), .vga_yide(vga_yide), .vga_data(dData),
    .blk_x(dX), .blk_y(dY), .edge_hits(dHits), .pending(dPend)
  );

  block_mover_ctrl #(.WRAP(0), .X0(760)) dutClamp (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .frame_tick(frame_tick),
    .vga_xide(vga_xide), .vga_yide(vga_yide), .vga_data(cData),
    .blk_x(cX), .blk_y(cY), .edge_hits(cHits), .pending(cPend)
  );

  block_mover_ctrl #(.WRAP(1), .X0(0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .frame_tick(frame_tick),
    .vga_xide(vga_xide), .vga_yide(vga_yide), .vga_data(wData),
    .blk_x(wX), .blk_y(wY), .edge_hits(wHits), .pending(wPend)
  );

  // Stimulus helpers: inputs change 1 time unit after the rising edge
  task automatic doReset();
    key_up = 0; key_down = 0; key_left = 0; key_right = 0; frame_tick = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulseKey(input int which);
    @(posedge clk); #1;
    case (which)
      0: key_up = 1;
      1: key_down = 1;
      2: key_left = 1;
      default: key_right = 1;
    endcase
    @(posedge clk); #1;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
  endtask

  // Returns 1 time unit after the edge that samples the tick (DUT in COMMIT)
  task automatic pulseTick();
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
  endtask

  task automatic stepCycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    doReset();
    repeat (3) begin
      pulseTick();
      stepCycle();
    end
    checks++; if (dX !== 10'd380) begin errors++; $display("[TB] FAIL reset_blk_x actual %0d required 380", dX); end
    checks++; if (dY !== 10'd280) begin errors++; $display("[TB] FAIL reset_blk_y actual %0d required 280", dY); end
    checks++; if (dHits !== 8'd0) begin errors++; $display("[TB] FAIL reset_edge_hits actual %0d required 0", dHits); end
    checks++; if (dPend !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending actual %0b required 0", dPend); end
    checks++; if (dData !== 8'h00) begin errors++; $display("[TB] FAIL reset_vga_data actual %h required 00", dData); end
  endtask

  task automatic test_move_deferred();
    doReset();
    repeat (3) pulseKey(3);
    checks++; if (dPend !== 1'b1) begin errors++; $display("[TB] FAIL move_pending actual %0b required 1", dPend); end
    checks++; if (dX !== 10'd380) begin errors++; $display("[TB] FAIL move_before_tick actual %0d required 380", dX); end
    pulseTick();
    checks++; if (dX !== 10'd380) begin errors++; $display("[TB] FAIL move_in_commit actual %0d required 380", dX); end
    stepCycle();
    checks++; if (dX !== 10'd388) begin errors++; $display("[TB] FAIL move_after_commit actual %0d required 388", dX); end
    checks++; if (dPend !== 1'b0) begin errors++; $display("[TB] FAIL move_idle_after actual %0b required 0", dPend); end
    checks++; if (dHits !== 8'd0) begin errors++; $display("[TB] FAIL move_no_hit actual %0d required 0", dHits); end
  endtask

  task automatic test_edges();
    doReset();
    pulseKey(3);
    pulseTick();
    stepCycle();
    checks++; if (cX !== 10'd760) begin errors++; $display("[TB] FAIL clamp_blk_x actual %0d required 760", cX); end
    checks++; if (cHits !== 8'd1) begin errors++; $display("[TB] FAIL clamp_hits actual %0d required 1", cHits); end
    doReset();
    pulseKey(2);
    pulseTick();
    stepCycle();
    checks++; if (wX !== 10'd760) begin errors++; $display("[TB] FAIL wrap_blk_x actual %0d required 760", wX); end
    checks++; if (wHits !== 8'd1) begin errors++; $display("[TB] FAIL wrap_hits actual %0d required 1", wHits); end
    checks++; if (dX !== 10'd372) begin errors++; $display("[TB] FAIL left_blk_x actual %0d required 372", dX); end
  endtask

  task automatic test_cancel_and_commit_key();
    doReset();
    pulseKey(2);
    pulseKey(3);
    pulseTick();
    stepCycle();
    checks++; if (dX !== 10'd380) begin errors++; $display("[TB] FAIL cancel_blk_x actual %0d required 380", dX); end
    checks++; if (cHits !== 8'd0) begin errors++; $display("[TB] FAIL cancel_hits actual %0d required 0", cHits); end
    // Press up in the COMMIT cycle of a down move
    pulseKey(1);
    pulseTick();
    key_up = 1;
    stepCycle();
    key_up = 0;
    checks++; if (dY !== 10'd288) begin errors++; $display("[TB] FAIL commit_down_y actual %0d required 288", dY); end
    checks++; if (dPend !== 1'b1) begin errors++; $display("[TB] FAIL commit_key_held actual %0b required 1", dPend); end
    pulseTick();
    stepCycle();
    checks++; if (dY !== 10'd280) begin errors++; $display("[TB] FAIL commit_key_y actual %0d required 280", dY); end
    checks++; if (dPend !== 1'b0) begin errors++; $display("[TB] FAIL commit_key_idle actual %0b required 0", dPend); end
  endtask

  task automatic test_pixel();
    int xs [4] = '{379, 380, 419, 420};
    logic [7:0] exp [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    doReset();
    for (int i = 0; i < 4; i++) begin
      vga_xide = 10'(xs[i]);
      vga_yide = 10'd280;
      stepCycle();
      checks++;
      if (dData !== exp[i]) begin
        errors++; $display("[TB] FAIL pixel_x%0d actual %h required %h", xs[i], dData, exp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vga_xide = 10'd380;
      vga_yide = 10'(xs[i] - 100);
      stepCycle();
      checks++;
      if (dData !== exp[i]) begin
        errors++; $display("[TB] FAIL pixel_y%0d actual %h required %h", xs[i] - 100, dData, exp[i]);
      end
    end
    vga_xide = 10'd419;
    vga_yide = 10'd319;
    stepCycle();
    checks++; if (dData !== 8'hFF) begin errors++; $display("[TB] FAIL pixel_corner actual %h required FF", dData); end
  endtask

  task automatic test_async_reset_and_saturation();
    doReset();
    pulseKey(3);
    pulseTick();
    stepCycle();
    vga_xide = 10'd390; vga_yide = 10'd290;
    pulseKey(0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dX !== 10'd380) begin errors++; $display("[TB] FAIL async_blk_x actual %0d required 380", dX); end
    checks++; if (dPend !== 1'b0) begin errors++; $display("[TB] FAIL async_pending actual %0b required 0", dPend); end
    checks++; if (dData !== 8'h00) begin errors++; $display("[TB] FAIL async_vga_data actual %h required 00", dData); end
    @(posedge clk); #1 rst_n = 1'b1;
    pulseTick();
    stepCycle();
    checks++; if (dY !== 10'd280) begin errors++; $display("[TB] FAIL async_lost_pulse actual %0d required 280", dY); end
    for (int n = 0; n < 300; n++) begin
      pulseKey(3);
      pulseTick();
      stepCycle();
      if (n == 254) begin
        checks++; if (cHits !== 8'd255) begin errors++; $display("[TB] FAIL sat_reach actual %0d required 255", cHits); end
      end
    end
    checks++; if (cHits !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold actual %0d required 255", cHits); end
    checks++; if (cX !== 10'd760) begin errors++; $display("[TB] FAIL sat_blk_x actual %0d required 760", cX); end
  endtask

  initial begin
    $display("[TB] block_mover_ctrl directed test start");
    test_reset();
    test_move_deferred();
    test_edges();
    test_cancel_and_commit_key();
    test_pixel();
    test_async_reset_and_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
